fb_inst_enc: RTL and testbench
==============================

Name: fb_inst_enc

Overview:
- Instruction encoder: the inverse of the immediate-extraction path in decode.
- Accepts decoded fields (format, opcode, registers, functs, 32-bit signed imm) over a valid/ready handshake.
- Packs them into an RV32I instruction word, tags each word with a sequential byte address, and buffers output in a 2-entry FIFO.
- Used by the self-test program loader and the instruction-memory preload path.

Parameters:
- RESET_ADDR, 32'h0000_0000, address tagged on the first word after reset.
- ADDR_STEP, 4, address increment per accepted word.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
- in_opcode  in  7  opcode[6:0]
- in_rd / in_rs1 / in_rs2  in  5 each  register indices
- in_funct3  in  3
- in_funct7  in  7  used by R only
- in_imm  in  `FB_32BITS  signed immediate; for U, the full value, upper 20 bits used
- addr_load  in  1  load address counter
- addr_val  in  `FB_32BITS  value to load
- out_valid  out  1
- out_ready  in  1
- out_inst  out  `FB_32BITS  encoded word
- out_addr  out  `FB_32BITS  byte address of word
- out_err  out  1  this word had an encoding error
- err_sticky  out  1  OR of all out_err since reset/clear
- err_clr  in  1  clears err_sticky

Behaviour:
- Reset, asynchronous:
  - out_valid=0, out_inst=0, out_addr=0, out_err=0, err_sticky=0.
  - Address counter=RESET_ADDR, S1 empty, FIFO empty; in_ready=1 from the first cycle after reset.
- Pipeline:
  - S1 holds the field register plus its tagged address.
  - Encode is combinational from S1 into the 2-entry FIFO.
  - The FIFO head drives the out_* ports.
- Handshakes:
  - Input accept = in_valid&in_ready. Output pop = out_valid&out_ready.
  - in_ready = !S1_full | fifo_can_write.
  - fifo_can_write = FIFO not full, or pop in the same cycle.
- Latency and throughput:
  - A word accepted at edge t is visible on out_* after edge t+1.
  - Sustained 1 word/cycle when out_ready is held 1.
  - out_* stay stable while out_valid=1 and out_ready=0.
- Encoding, all formats: word[6:0]=in_opcode.
  - R: funct7|rs2|rs1|funct3|rd.
  - I: imm[11:0]|rs1|funct3|rd.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0].
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11].
  - U: imm[31:12]|rd.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd.
  - Illegal fmt (6,7): word=32'h0000_0013 (NOP), out_err=1.
- Address counter:
  - On accept, the entry is tagged with the counter value, then counter += ADDR_STEP.
  - Wraps modulo 2^32, no flag.
  - addr_load without accept: counter=addr_val.
  - addr_load with accept in the same cycle: the entry is tagged addr_val, counter=addr_val+ADDR_STEP.
  - Already-buffered entries keep their tags.
- err_sticky:
  - Set on the pop of any word with out_err=1.
  - err_clr clears it. Clear and set in the same cycle: set wins.
- Boundary cases:
  - FIFO full and S1 full: in_ready=0.
  - FIFO full with a pop this cycle: S1 advances and a new input is accepted in the same cycle.
  - Empty FIFO: out_valid=0, out_* hold their last values.

Optional Feature:
- FB_ENC_RANGE_CHK_EN defined:
  - I/S: out_err=1 if imm is outside -2048..2047.
  - B: out_err=1 if imm is outside -4096..4094 or imm[0]=1.
  - J: out_err=1 if imm is outside -1048576..1048574 or imm[0]=1.
  - U: out_err=1 if imm[11:0]!=0.
  - R: no check.
  - The word is still emitted with truncated bits.
- Not defined: only illegal fmt raises out_err; immediates are silently truncated.

Decomposition:
- fb_defines.v additions:
  - FB_FMT_R..FB_FMT_J codes.
  - FB_NOP_INST=32'h0000_0013.
  - FB_IMM12/13/21 range constants.
- One sub-module, fb_enc_fifo2: 2-entry FIFO; width = 32+32+1 (inst, addr, err); full/empty/push/pop.
- Packing logic stays in fb_inst_enc.

Test Plan:
- I-type addi x1,x0,5 (fmt=1, op=0010011, rd=1, rs1=0, f3=0, imm=5), out_ready=1 -> out_inst=32'h00500093, out_addr=0 two edges later, out_err=0.
- B-type beq x1,x2,-8 (fmt=3, op=1100011) -> out_inst=32'hFE208CE3. J-type jal x1,2048 (op=1101111) -> 32'h001000EF.
- Four back-to-back inputs, out_ready=0 -> in_ready drops after 3 accepted; release out_ready -> words popped in order, addresses 0,4,8,C.
- addr_load=1, addr_val=32'hFFFF_FFFC with accept, then a second word -> tags FFFF_FFFC then 0000_0000 (wrap).
- FB_ENC_RANGE_CHK_EN on, I-type imm=4096 -> out_err=1, err_sticky=1. err_clr -> err_sticky=0. fmt=7 -> out_inst=0000_0013, out_err=1.
- rst_n asserted mid-burst with 2 entries buffered -> out_valid=0 immediately; after release the next word is tagged RESET_ADDR.

Source files
------------

// File: rtl/fb_inst_enc_pkg.sv
// Shared encodings and types for the RV32I instruction encoder.
// The optional FB_ENC_RANGE_CHK_EN build uses the immediate range constants.
package fb_inst_enc_pkg;

  typedef enum logic [2:0] {
    FB_FMT_R = 3'd0,
    FB_FMT_I = 3'd1,
    FB_FMT_S = 3'd2,
    FB_FMT_B = 3'd3,
    FB_FMT_U = 3'd4,
    FB_FMT_J = 3'd5
  } fb_fmt_e;

  localparam logic [31:0] FB_NOP_INST = 32'h0000_0013;

  localparam logic signed [31:0] FB_IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] FB_IMM12_MAX = 32'sd2047;
  localparam logic signed [31:0] FB_IMM13_MIN = -32'sd4096;
  localparam logic signed [31:0] FB_IMM13_MAX = 32'sd4094;
  localparam logic signed [31:0] FB_IMM21_MIN = -32'sd1048576;
  localparam logic signed [31:0] FB_IMM21_MAX = 32'sd1048574;

  // fmt is kept raw so the illegal codes 6 and 7 survive into the encoder
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fb_fields_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } fb_enc_word_t;

endpackage

// File: rtl/fb_enc_fifo2.sv
// Two-entry output FIFO: a head register that directly drives the outputs
// (holding its last value when empty) backed by one tail register.
module fb_enc_fifo2 #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] hd_r;
  logic [W-1:0] tl_r;
  logic         hd_valid_r;
  logic         tl_valid_r;
  logic         pop_s;
  logic         push_s;

  assign pop_s  = pop & hd_valid_r;
  assign push_s = push & (~(hd_valid_r & tl_valid_r) | pop_s);
  assign dout   = hd_r;
  assign full   = hd_valid_r & tl_valid_r;
  assign empty  = ~hd_valid_r;

  // Head/tail storage: the tail moves up on pop, new data lands in the first free slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd_r       <= '0;
      tl_r       <= '0;
      hd_valid_r <= 1'b0;
      tl_valid_r <= 1'b0;
    end else if (pop_s) begin
      if (tl_valid_r) begin
        hd_r       <= tl_r;
        tl_valid_r <= push_s;
        if (push_s) begin
          tl_r <= din;
        end
      end else begin
        hd_valid_r <= push_s;
        if (push_s) begin
          hd_r <= din;
        end
      end
    end else if (push_s) begin
      if (hd_valid_r) begin
        tl_r       <= din;
        tl_valid_r <= 1'b1;
      end else begin
        hd_r       <= din;
        hd_valid_r <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_inst_enc.sv
// RV32I instruction encoder: field register (S1) -> combinational packing -> 2-entry FIFO.
// Define FB_ENC_RANGE_CHK_EN to flag immediates that do not fit their format.
module fb_inst_enc
  import fb_inst_enc_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  input  logic        addr_load,
  input  logic [31:0] addr_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic        err_sticky,
  input  logic        err_clr
);

  fb_fields_t   fields_in_s;
  fb_fields_t   s1_r;
  logic         s1_full_r;
  logic [31:0]  s1_addr_r;
  logic [31:0]  addr_cnt_r;
  logic [31:0]  tag_s;
  logic         accept_s;
  logic         push_s;
  logic         pop_s;
  logic         fifo_full_s;
  logic         fifo_empty_s;
  logic         fifo_can_write_s;
  logic [31:0]  enc_inst_s;
  logic         enc_err_s;
  logic         rng_err_s;
  logic         err_sticky_r;
  fb_enc_word_t push_word_s;
  fb_enc_word_t head_s;

  assign fields_in_s = {in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm};

  assign pop_s            = out_valid & out_ready;
  assign fifo_can_write_s = ~fifo_full_s | pop_s;
  assign in_ready         = ~s1_full_r | fifo_can_write_s;
  assign accept_s         = in_valid & in_ready;
  assign push_s           = s1_full_r & fifo_can_write_s;
  // A same-cycle load overrides the counter for the word being accepted
  assign tag_s            = addr_load ? addr_val : addr_cnt_r;

  // S1 field register and address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r       <= '0;
      s1_full_r  <= 1'b0;
      s1_addr_r  <= '0;
      addr_cnt_r <= RESET_ADDR;
    end else if (accept_s) begin
      s1_r       <= fields_in_s;
      s1_full_r  <= 1'b1;
      s1_addr_r  <= tag_s;
      addr_cnt_r <= tag_s + ADDR_STEP;
    end else begin
      if (push_s) begin
        s1_full_r <= 1'b0;
      end
      if (addr_load) begin
        addr_cnt_r <= addr_val;
      end
    end
  end

`ifdef FB_ENC_RANGE_CHK_EN
  logic signed [31:0] imm_s;
  assign imm_s = s1_r.imm;

  // Immediate range check; the word itself is still emitted truncated
  always_comb begin
    rng_err_s = 1'b0;
    case (s1_r.fmt)
      FB_FMT_I, FB_FMT_S: rng_err_s = (imm_s < FB_IMM12_MIN) | (imm_s > FB_IMM12_MAX);
      FB_FMT_B: rng_err_s = (imm_s < FB_IMM13_MIN) | (imm_s > FB_IMM13_MAX) | imm_s[0];
      FB_FMT_J: rng_err_s = (imm_s < FB_IMM21_MIN) | (imm_s > FB_IMM21_MAX) | imm_s[0];
      FB_FMT_U: rng_err_s = (s1_r.imm[11:0] != 12'd0);
      default:  rng_err_s = 1'b0;
    endcase
  end
`else
  assign rng_err_s = 1'b0;
`endif

  // Field packing per instruction format
  always_comb begin
    enc_inst_s = FB_NOP_INST;
    enc_err_s  = rng_err_s;
    case (s1_r.fmt)
      FB_FMT_R: enc_inst_s = {s1_r.funct7, s1_r.rs2, s1_r.rs1, s1_r.funct3, s1_r.rd, s1_r.opcode};
      FB_FMT_I: enc_inst_s = {s1_r.imm[11:0], s1_r.rs1, s1_r.funct3, s1_r.rd, s1_r.opcode};
      FB_FMT_S: enc_inst_s = {s1_r.imm[11:5], s1_r.rs2, s1_r.rs1, s1_r.funct3,
                              s1_r.imm[4:0], s1_r.opcode};
      FB_FMT_B: enc_inst_s = {s1_r.imm[12], s1_r.imm[10:5], s1_r.rs2, s1_r.rs1, s1_r.funct3,
                              s1_r.imm[4:1], s1_r.imm[11], s1_r.opcode};
      FB_FMT_U: enc_inst_s = {s1_r.imm[31:12], s1_r.rd, s1_r.opcode};
      FB_FMT_J: enc_inst_s = {s1_r.imm[20], s1_r.imm[10:1], s1_r.imm[11], s1_r.imm[19:12],
                              s1_r.rd, s1_r.opcode};
      default: begin
        enc_inst_s = FB_NOP_INST;
        enc_err_s  = 1'b1;
      end
    endcase
  end

  assign push_word_s = {enc_inst_s, s1_addr_r, enc_err_s};

  fb_enc_fifo2 #(
    .W($bits(fb_enc_word_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   (push_word_s),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign out_valid = ~fifo_empty_s;
  assign out_inst  = head_s.inst;
  assign out_addr  = head_s.addr;
  assign out_err   = head_s.err;

  // Sticky error: a flagged pop wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_r <= 1'b0;
    end else begin
      err_sticky_r <= (pop_s & out_err) | (err_sticky_r & ~err_clr);
    end
  end

  assign err_sticky = err_sticky_r;

endmodule

// File: tb/tb_fb_inst_enc.sv
// Directed bench for fb_inst_enc with hand-computed instruction words.
// Range-check expectations follow FB_ENC_RANGE_CHK_EN when it is defined.
module tb_fb_inst_enc;

`ifdef FB_ENC_RANGE_CHK_EN
  localparam logic RCHK = 1'b1;
`else
  localparam logic RCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = 3'd0;
  logic [6:0]  in_opcode = 7'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [4:0]  in_rs1 = 5'd0;
  logic [4:0]  in_rs2 = 5'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [6:0]  in_funct7 = 7'd0;
  logic [31:0] in_imm = 32'd0;
  logic        addr_load = 1'b0;
  logic [31:0] addr_val = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  logic        err_sticky;
  logic        err_clr = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  fb_inst_enc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .addr_load  (addr_load),
    .addr_val   (addr_val),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_addr   (out_addr),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input logic ld, input logic [31:0] ldv);
    int n;
    set_fields(fmt, op, rd, rs1, rs2, f3, f7, imm);
    addr_load = ld; addr_val = ldv; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk_val("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; addr_load = 1'b0;
  endtask

  // Checks the FIFO head, then pops it over one clock
  task automatic pop_chk(input string tag, input logic [31:0] inst, input logic [31:0] addr,
                         input logic err);
    chk_val({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk_val({tag, "_inst"}, out_inst, inst);
    chk_val({tag, "_addr"}, out_addr, addr);
    chk_val({tag, "_err"}, 32'(out_err), 32'(err));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_val("rst_valid", 32'(out_valid), 32'd0);
    chk_val("rst_inst", out_inst, 32'd0);
    chk_val("rst_addr", out_addr, 32'd0);
    chk_val("rst_err", 32'(out_err), 32'd0);
    chk_val("rst_sticky", 32'(err_sticky), 32'd0);
    chk_val("rst_ready", 32'(in_ready), 32'd1);

    // addi x1,x0,5 with out_ready held high: two-edge latency, then hold when empty
    out_ready = 1'b1;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'd0);
    chk_val("lat_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk_val("addi_valid", 32'(out_valid), 32'd1);
    chk_val("addi_inst", out_inst, 32'h0050_0093);
    chk_val("addi_addr", out_addr, 32'h0000_0000);
    chk_val("addi_err", 32'(out_err), 32'd0);
    @(negedge clk);
    chk_val("empty_valid", 32'(out_valid), 32'd0);
    chk_val("empty_hold", out_inst, 32'h0050_0093);
    out_ready = 1'b0;

    // Burst with out_ready low: beq, jal, sub fill S1 + FIFO
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8, 1'b1, 32'd0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'd0);
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 1'b0, 32'd0);
    chk_val("full_ready", 32'(in_ready), 32'd0);
    chk_val("stall_inst0", out_inst, 32'hFE20_8CE3);
    @(negedge clk);
    chk_val("stall_inst1", out_inst, 32'hFE20_8CE3);
    chk_val("stall_addr1", out_addr, 32'h0000_0000);
    // sw x2,8(x1) presented while full; accepted on the popping edge
    set_fields(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk_val("pop_ready", 32'(in_ready), 32'd1);
    pop_chk("beq", 32'hFE20_8CE3, 32'h0000_0000, 1'b0);
    in_valid = 1'b0;
    pop_chk("jal", 32'h0010_00EF, 32'h0000_0004, 1'b0);
    pop_chk("sub", 32'h4020_81B3, 32'h0000_0008, 1'b0);
    pop_chk("sw", 32'h0020_A423, 32'h0000_000C, 1'b0);
    chk_val("drain_valid", 32'(out_valid), 32'd0);

    // addr_load without accept, then lui x5,0x12345
    addr_load = 1'b1; addr_val = 32'h0000_0100;
    @(negedge clk);
    addr_load = 1'b0;
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0, 32'd0);
    @(negedge clk);
    pop_chk("lui", 32'h1234_52B7, 32'h0000_0100, 1'b0);

    // Load with accept at the top of the address space, then wrap
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'hFFFF_FFFC);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'd0);
    pop_chk("wrap0", 32'h0050_0093, 32'hFFFF_FFFC, 1'b0);
    pop_chk("wrap1", 32'h0050_0093, 32'h0000_0000, 1'b0);

    // I-type imm=4096 truncates to 0; flagged only with range checking
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 1'b0, 32'd0);
    @(negedge clk);
    pop_chk("rng_i", 32'h0000_0093, 32'h0000_0004, RCHK);
    chk_val("rng_sticky", 32'(err_sticky), 32'(RCHK));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk_val("clr_sticky", 32'(err_sticky), 32'd0);

    // U-type with nonzero low bits
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5678, 1'b0, 32'd0);
    @(negedge clk);
    pop_chk("rng_u", 32'h1234_52B7, 32'h0000_0008, RCHK);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // Illegal fmt 7 -> NOP with error
    send(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
    pop_chk("ill7", 32'h0000_0013, 32'h0000_000C, 1'b1);
    chk_val("ill7_sticky", 32'(err_sticky), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk_val("ill7_clr", 32'(err_sticky), 32'd0);

    // Illegal fmt 6 popped while err_clr is high: set wins
    send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
    err_clr = 1'b1;
    pop_chk("ill6", 32'h0000_0013, 32'h0000_0010, 1'b1);
    err_clr = 1'b0;
    chk_val("setwins_sticky", 32'(err_sticky), 32'd1);

    // Reset mid-burst with two words buffered
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 32'd0);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 32'd0);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'd0);
    chk_val("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("arst_valid", 32'(out_valid), 32'd0);
    chk_val("arst_inst", out_inst, 32'd0);
    chk_val("arst_sticky", 32'(err_sticky), 32'd0);
    chk_val("arst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'd0);
    @(negedge clk);
    pop_chk("post_rst", 32'h0050_0093, 32'h0000_0000, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
